// File: rtl/pipe_addsub_pkg.sv
// Shared types and elaboration helpers for the segmented pipelined adder/subtractor.
package pipe_addsub_pkg;

  // Control word carried from one segment stage to the next.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  function automatic int nseg(input int width, input int seg);
    return (seg > 0) ? width / seg : 1;
  endfunction

  function automatic bit seg_cfg_ok(input int width, input int seg);
    return (seg > 0) && (width >= seg) && (width % seg == 0);
  endfunction

endpackage

// File: rtl/pipe_addsub_stage.sv
// One pipeline segment: SEG-bit add with carry-in, registered sum slice and carry/valid.
module pipe_addsub_stage
  import pipe_addsub_pkg::*;
#(
  parameter int SEG = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           adv,
  input  logic [SEG-1:0] a_seg,
  input  logic [SEG-1:0] b_seg,
  input  stage_ctl_t     ctl_in,
  output logic [SEG-1:0] s_q,
  output stage_ctl_t     ctl_q
);

  logic [SEG:0] seg_sum;

  assign seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, ctl_in.carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q   <= '0;
      ctl_q <= '0;
    end else if (adv) begin
      s_q   <= seg_sum[SEG-1:0];
      ctl_q <= '{valid: ctl_in.valid, carry: seg_sum[SEG]};
    end
  end

endmodule

// File: rtl/pipe_addsub_seg.sv
// Segmented pipelined adder/subtractor: stage 0 registers operands, then one
// carry-chained stage per SEG-bit segment with operand skew and result deskew.
module pipe_addsub_seg
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = nseg(WIDTH, SEG);

  if (!seg_cfg_ok(WIDTH, SEG)) begin : g_cfg_err
    $error("pipe_addsub_seg: WIDTH must be a non-zero multiple of SEG");
  end

  logic             adv;
  logic [WIDTH-1:0] a_p0, b_p0;
  stage_ctl_t       ctl_p0;
  logic [WIDTH-1:0] res_last;
  stage_ctl_t       ctl_last;
  logic             a_msb_last, b_msb_last;

  // The whole pipe moves together; a stalled output freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 0: capture operands, B already inverted for subtract.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p0   <= '0;
      b_p0   <= '0;
      ctl_p0 <= '0;
    end else if (adv) begin
      a_p0   <= a;
      b_p0   <= sub ? ~b : b;
      ctl_p0 <= '{valid: in_valid, carry: cin};
    end
  end

  // Stages 1..NSEG: stage k adds segment k-1 and carries the rest along.
  for (genvar k = 1; k <= NSEG; k++) begin : g_seg
    localparam int OPW = WIDTH - (k - 1) * SEG;

    logic [OPW-1:0]     a_in, b_in;
    stage_ctl_t         ctl_in, ctl_q;
    logic [SEG-1:0]     s_q;
    logic [k*SEG-1:0]   res;

    if (k == 1) begin : g_first
      assign a_in   = a_p0;
      assign b_in   = b_p0;
      assign ctl_in = ctl_p0;
      assign res    = s_q;
    end else begin : g_next
      logic [(k-1)*SEG-1:0] lo_q;
      assign a_in   = g_seg[k-1].g_fwd.a_q;
      assign b_in   = g_seg[k-1].g_fwd.b_q;
      assign ctl_in = g_seg[k-1].ctl_q;
      assign res    = {s_q, lo_q};
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   lo_q <= '0;
        else if (adv) lo_q <= g_seg[k-1].res;
      end
    end

    pipe_addsub_stage #(.SEG(SEG)) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv    (adv),
      .a_seg  (a_in[SEG-1:0]),
      .b_seg  (b_in[SEG-1:0]),
      .ctl_in (ctl_in),
      .s_q    (s_q),
      .ctl_q  (ctl_q)
    );

    if (k < NSEG) begin : g_fwd
      logic [OPW-SEG-1:0] a_q, b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[OPW-1:SEG];
          b_q <= b_in[OPW-1:SEG];
        end
      end
    end else begin : g_last
      // Operand sign bits travel with the top segment for the overflow flag.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_msb_last <= 1'b0;
          b_msb_last <= 1'b0;
        end else if (adv) begin
          a_msb_last <= a_in[SEG-1];
          b_msb_last <= b_in[SEG-1];
        end
      end
      assign res_last = res;
      assign ctl_last = ctl_q;
    end
  end

  assign out_valid = ctl_last.valid;
  assign sum       = res_last;
  assign cout      = ctl_last.carry;
  assign ovf       = (a_msb_last == b_msb_last) && (res_last[WIDTH-1] != a_msb_last);

endmodule
